sram_bist_sequencer: RTL and testbench
======================================

SRAM_BIST_SEQUENCER -- requirements
Module: sram_bist_sequencer

Interface
REQ-001 Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 Resetn  in  1  asynchronous, active-low reset.
REQ-003 run_request  in  1  level input; a rising edge starts a test session.
REQ-004 num_runs  in  4  BIST passes per session, sampled at session start; 0 is treated as 1.
REQ-005 user_address / user_write_data / user_we_n  in  18/16/1  normal-mode SRAM bus.
REQ-006 BIST_address / BIST_write_data / BIST_we_n  in  18/16/1  SRAM bus driven by the BIST engine.
REQ-007 BIST_finish / BIST_mismatch  in  1/1  BIST engine status.
REQ-008 BIST_start  out  1  start pulse to the BIST engine.
REQ-009 SRAM_address / SRAM_write_data / SRAM_we_n  out  18/16/1  muxed bus to the SRAM controller.
REQ-010 busy / done / pass / timeout  out  1 each  session status.
REQ-011 run_count / fail_count  out  4/4  completed passes / passes that reported a mismatch.

Function
REQ-012 run_request shall be registered once; session start = run_request & ~run_request_buf.
REQ-013 The states shall be S_IDLE, S_WAIT_LOW, S_WAIT_HIGH and S_DONE.
REQ-014 S_IDLE, start edge: clear run_count, fail_count, done, pass and timeout; latch the effective run count; set busy=1, bus_sel=BIST and BIST_start=1; go to S_WAIT_LOW.
REQ-015 BIST_start shall be registered and high for exactly one cycle per pass.
REQ-016 S_WAIT_LOW: BIST_start=0; wait for BIST_finish==0; a 20-bit watchdog increments every cycle.
  - On BIST_finish==0: clear the watchdog and go to S_WAIT_HIGH.
  - Watchdog reaching 8: set timeout=1 and go to S_DONE.
REQ-017 S_WAIT_HIGH: wait for BIST_finish==1 while the watchdog increments.
  - Watchdog reaching 20'hFFFFF: set timeout=1 and go to S_DONE.
REQ-018 On BIST_finish==1 in S_WAIT_HIGH, BIST_mismatch shall be sampled in the same cycle.
  - fail_count increments if BIST_mismatch=1, saturating at 15.
  - run_count increments, 4-bit.
REQ-019 After a REQ-018 update: if the new run_count equals the latched run count, go to S_DONE. Otherwise set BIST_start=1, clear the watchdog and go to S_WAIT_LOW.
REQ-020 S_DONE (one cycle): busy=0, done=1, bus_sel=USER, pass = (fail_count==0 after the final update) & ~timeout; then go to S_IDLE.
REQ-021 done, pass, timeout, run_count and fail_count shall hold until the next session start.
REQ-022 Start edges while busy=1 shall be ignored.
REQ-023 The SRAM bus mux shall be combinational from the registered bus_sel.
  - bus_sel=USER: SRAM_* = user_*.
  - bus_sel=BIST: SRAM_* = BIST_*.
  - User inputs shall have no effect on the SRAM bus while bus_sel=BIST.
REQ-024 On timeout, bus_sel shall return to USER in the same cycle that done is asserted.
REQ-025 A session start and a falling run_request in the same cycle shall still start a session; only the registered edge matters.

Reset
REQ-026 While Resetn=0, outputs shall be: BIST_start=0, busy=0, done=0, pass=0, timeout=0, run_count=0, fail_count=0, bus_sel=USER, state=S_IDLE, watchdog=0.
REQ-027 Reset mid-session shall abort immediately. No further BIST_start pulses shall occur, and the SRAM bus shall revert to the user inputs asynchronously.

Verification
REQ-028 Fault-free BIST stub (finish low 1 cycle after start, high 600 cycles later, mismatch=0), num_runs=3 -> 3 single-cycle BIST_start pulses, then done=1, pass=1, run_count=3, fail_count=0, busy=0.
REQ-029 Stub reports mismatch=1 on pass 2 of 2 -> done=1, pass=0, fail_count=1, run_count=2.
REQ-030 Stub holds BIST_finish=1 permanently -> timeout=1, done=1, pass=0, run_count=0, exactly 8 cycles after the start edge.
REQ-031 busy=0, user_address=18'h12345, user_we_n=0 -> SRAM_address=18'h12345 and SRAM_we_n=0 in the same cycle. During a session with BIST_address=18'h00007 -> SRAM_address=18'h00007 regardless of user inputs.
REQ-032 Resetn pulsed low during S_WAIT_HIGH of pass 1 -> all outputs per REQ-026 and no BIST_start pulse afterwards. A new run_request edge with num_runs=0 -> exactly 1 pass.
REQ-033 run_request held high for an entire session and beyond -> exactly one session; a second session only after run_request goes low and then high again.

Source files
------------

// File: rtl/sram_bist_sequencer.sv
// Session sequencer for an external SRAM BIST engine: runs N passes, counts
// failures, guards each handshake phase with a watchdog, and muxes the SRAM bus.
module sram_bist_sequencer (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        run_request,
    input  logic [3:0]  num_runs,
    input  logic [17:0] user_address,
    input  logic [15:0] user_write_data,
    input  logic        user_we_n,
    input  logic [17:0] BIST_address,
    input  logic [15:0] BIST_write_data,
    input  logic        BIST_we_n,
    input  logic        BIST_finish,
    input  logic        BIST_mismatch,
    output logic        BIST_start,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [3:0]  run_count,
    output logic [3:0]  fail_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOW  = 2'd1;
    localparam logic [1:0] S_WAIT_HIGH = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic SEL_USER = 1'b0;
    localparam logic SEL_BIST = 1'b1;

    localparam logic [19:0] WD_LOW_LIMIT  = 20'd8;
    localparam logic [19:0] WD_HIGH_LIMIT = 20'hFFFFF;

    logic        run_request_buf;
    logic        session_start;
    logic        bus_sel;
    logic [1:0]  state;
    logic [19:0] watchdog;
    logic [3:0]  runs_target;

    logic [19:0] watchdog_inc;
    logic [3:0]  run_count_inc;
    logic [3:0]  fail_count_upd;

    assign session_start  = run_request & ~run_request_buf;
    assign watchdog_inc   = watchdog + 20'd1;
    assign run_count_inc  = run_count + 4'd1;
    assign fail_count_upd = (BIST_mismatch && (fail_count != 4'hF)) ? fail_count + 4'd1
                                                                    : fail_count;

    // bus_sel resets asynchronously, so the SRAM bus falls back to user inputs at once
    assign SRAM_address    = (bus_sel == SEL_BIST) ? BIST_address    : user_address;
    assign SRAM_write_data = (bus_sel == SEL_BIST) ? BIST_write_data : user_write_data;
    assign SRAM_we_n       = (bus_sel == SEL_BIST) ? BIST_we_n       : user_we_n;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            run_request_buf <= 1'b0;
            state           <= S_IDLE;
            watchdog        <= '0;
            runs_target     <= '0;
            bus_sel         <= SEL_USER;
            BIST_start      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            run_count       <= '0;
            fail_count      <= '0;
        end else begin
            run_request_buf <= run_request;
            case (state)
                S_IDLE, S_DONE: begin
                    if (session_start) begin
                        run_count   <= '0;
                        fail_count  <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        runs_target <= (num_runs == 4'd0) ? 4'd1 : num_runs;
                        busy        <= 1'b1;
                        bus_sel     <= SEL_BIST;
                        BIST_start  <= 1'b1;
                        watchdog    <= '0;
                        state       <= S_WAIT_LOW;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_LOW: begin
                    BIST_start <= 1'b0;
                    if (!BIST_finish) begin
                        watchdog <= '0;
                        state    <= S_WAIT_HIGH;
                    end else if (watchdog_inc == WD_LOW_LIMIT) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        bus_sel <= SEL_USER;
                        state   <= S_DONE;
                    end else begin
                        watchdog <= watchdog_inc;
                    end
                end
                S_WAIT_HIGH: begin
                    if (BIST_finish) begin
                        run_count  <= run_count_inc;
                        fail_count <= fail_count_upd;
                        watchdog   <= '0;
                        if (run_count_inc == runs_target) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (fail_count_upd == 4'd0);
                            bus_sel <= SEL_USER;
                            state   <= S_DONE;
                        end else begin
                            BIST_start <= 1'b1;
                            state      <= S_WAIT_LOW;
                        end
                    end else if (watchdog_inc == WD_HIGH_LIMIT) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        bus_sel <= SEL_USER;
                        state   <= S_DONE;
                    end else begin
                        watchdog <= watchdog_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Directed bench for sram_bist_sequencer with a behavioural BIST engine stub.
module tb_sram_bist_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        run_request;
    logic [3:0]  num_runs;
    logic [17:0] user_address;
    logic [15:0] user_write_data;
    logic        user_we_n;
    logic [17:0] BIST_address;
    logic [15:0] BIST_write_data;
    logic        BIST_we_n;
    logic        BIST_finish;
    logic        BIST_mismatch = 1'b0;
    logic        BIST_start;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy, done, pass, timeout;
    logic [3:0]  run_count, fail_count;

    int n_checks = 0;
    int n_fail   = 0;

    // engine stub state
    logic stub_en      = 1'b1;
    logic force_finish = 1'b1;
    logic stub_finish  = 1'b1;
    int   stub_lat     = 10;
    int   stub_cnt     = 0;
    int   stub_pass    = 0;
    int   mm_abs       = -1;

    int pulses = 0;
    int multi  = 0;
    logic prev_start = 1'b0;

    sram_bist_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .run_request(run_request), .num_runs(num_runs),
        .user_address(user_address), .user_write_data(user_write_data), .user_we_n(user_we_n),
        .BIST_address(BIST_address), .BIST_write_data(BIST_write_data), .BIST_we_n(BIST_we_n),
        .BIST_finish(BIST_finish), .BIST_mismatch(BIST_mismatch), .BIST_start(BIST_start),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .run_count(run_count), .fail_count(fail_count)
    );

    always #5 Clock = ~Clock;

    assign BIST_finish = stub_en ? stub_finish : force_finish;

    always @(negedge Clock) begin
        if (!Resetn) begin
            stub_cnt      = 0;
            stub_finish   = 1'b1;
            BIST_mismatch = 1'b0;
        end else if (BIST_start) begin
            stub_pass     = stub_pass + 1;
            stub_cnt      = stub_lat;
            stub_finish   = 1'b0;
            BIST_mismatch = 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                stub_finish   = 1'b1;
                BIST_mismatch = (stub_pass == mm_abs);
            end
        end
    end

    always @(posedge Clock) begin
        if (BIST_start) pulses = pulses + 1;
        if (BIST_start && prev_start) multi = multi + 1;
        prev_start = BIST_start;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    int p0;
    int m0;

    initial begin
        Resetn = 1'b0; run_request = 1'b0; num_runs = 4'd0;
        user_address = '0; user_write_data = '0; user_we_n = 1'b1;
        BIST_address = 18'h00007; BIST_write_data = 16'hA5A5; BIST_we_n = 1'b1;
        tick(2);
        check("rst_start",   BIST_start, 0);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_pass",    pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_runs",    run_count, 0);
        check("rst_fails",   fail_count, 0);
        Resetn = 1'b1;
        tick(2);

        // idle mux follows user bus immediately
        user_address = 18'h12345; user_write_data = 16'hBEEF; user_we_n = 1'b0;
        #1;
        check("idle_addr", SRAM_address, 18'h12345);
        check("idle_we",   SRAM_we_n, 0);
        check("idle_data", SRAM_write_data, 16'hBEEF);

        // three clean passes, 600-cycle engine latency
        stub_lat = 600; mm_abs = -1; p0 = pulses; m0 = multi;
        num_runs = 4'd3; run_request = 1'b1;
        tick(1);
        run_request = 1'b0;
        check("s1_busy", busy, 1);
        user_address = 18'h3FFFF; user_write_data = 16'h1234;
        #1;
        check("s1_bist_addr", SRAM_address, 18'h00007);
        check("s1_bist_we",   SRAM_we_n, 1);
        check("s1_bist_data", SRAM_write_data, 16'hA5A5);
        wait_done("s1_done_in_time", 3000);
        check("s1_pulses", pulses - p0, 3);
        check("s1_single", multi - m0, 0);
        check("s1_pass",   pass, 1);
        check("s1_runs",   run_count, 3);
        check("s1_fails",  fail_count, 0);
        check("s1_busy_end", busy, 0);
        check("s1_timeout",  timeout, 0);
        check("s1_user_addr", SRAM_address, 18'h3FFFF);
        tick(5);
        check("s1_hold_done", done, 1);
        check("s1_hold_runs", run_count, 3);

        // mismatch reported on pass 2 of 2
        stub_lat = 10; mm_abs = stub_pass + 2; p0 = pulses;
        num_runs = 4'd2; run_request = 1'b1;
        tick(1);
        run_request = 1'b0;
        check("s2_done_cleared", done, 0);
        wait_done("s2_done_in_time", 200);
        check("s2_pulses", pulses - p0, 2);
        check("s2_pass",  pass, 0);
        check("s2_fails", fail_count, 1);
        check("s2_runs",  run_count, 2);
        tick(3);

        // finish stuck high: timeout 8 cycles after the start edge
        stub_en = 1'b0; force_finish = 1'b1; mm_abs = -1;
        num_runs = 4'd5; run_request = 1'b1;
        tick(8);
        check("to_not_yet_done", done, 0);
        check("to_still_busy",   busy, 1);
        tick(1);
        check("to_done",    done, 1);
        check("to_timeout", timeout, 1);
        check("to_pass",    pass, 0);
        check("to_runs",    run_count, 0);
        check("to_busy",    busy, 0);
        check("to_user_addr", SRAM_address, 18'h3FFFF);
        run_request = 1'b0;
        tick(15);
        stub_en = 1'b1;
        tick(2);

        // run_request held high: a single session only
        p0 = pulses; num_runs = 4'd1; run_request = 1'b1;
        tick(1);
        wait_done("s3_done_in_time", 200);
        tick(30);
        check("s3_one_session", pulses - p0, 1);
        check("s3_idle", busy, 0);
        check("s3_done_held", done, 1);
        run_request = 1'b0;
        tick(1);
        run_request = 1'b1;
        tick(1);
        check("s3_restart_busy", busy, 1);
        wait_done("s3b_done_in_time", 200);
        check("s3_two_sessions", pulses - p0, 2);
        run_request = 1'b0;
        tick(2);

        // reset during the wait-high phase of pass 1
        stub_lat = 600; p0 = pulses;
        num_runs = 4'd2; run_request = 1'b1;
        tick(1);
        run_request = 1'b0;
        tick(20);
        check("r_busy_before", busy, 1);
        check("r_bist_bus",    SRAM_address, 18'h00007);
        Resetn = 1'b0;
        #1;
        check("r_busy",  busy, 0);
        check("r_start", BIST_start, 0);
        check("r_done",  done, 0);
        check("r_runs",  run_count, 0);
        check("r_user_bus", SRAM_address, 18'h3FFFF);
        p0 = pulses;
        tick(3);
        Resetn = 1'b1;
        tick(50);
        check("r_no_pulse", pulses - p0, 0);
        stub_lat = 10; num_runs = 4'd0; run_request = 1'b1;
        tick(1);
        run_request = 1'b0;
        wait_done("r0_done_in_time", 200);
        check("r0_pulses", pulses - p0, 1);
        check("r0_runs",   run_count, 1);
        check("r0_pass",   pass, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
